// File: rtl/framebuf_2port_if.sv
// Bus bundle for framebuf_2port: write port, read port, clear control and status.
// The master drives requests; the slave (the frame buffer) drives read data and status.
interface framebuf_2port_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 19
);
   logic              we;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] data_in;
   logic              re;
   logic [ADDR_W-1:0] read_addr;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              clear;
   logic              busy;
   logic              wr_drop;

   modport master (
      output we, write_addr, data_in, re, read_addr, clear,
      input  data_out, data_valid, busy, wr_drop
   );

   modport slave (
      input  we, write_addr, data_in, re, read_addr, clear,
      output data_out, data_valid, busy, wr_drop
   );
endinterface

// File: rtl/framebuf_2port.sv
// Frame buffer: one write port, one 1-cycle read port and a background clear sweep.
// Optional macro FRAMEBUF_BYPASS_EN forwards a same-cycle write to a read of that address.
module framebuf_2port #(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 19,
   parameter int                DEPTH     = 307200,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input logic             clk,
   input logic             reset,
   framebuf_2port_if.slave bus
);
   localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_CLEAR = 1'b1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              data_valid_q, data_valid_d;
   logic              wr_drop_q, wr_drop_d;

   logic              busy;
   logic              wr_in_range, rd_in_range;
   logic              user_we, sweep_we, mem_we;
   logic [IDX_W-1:0]  wr_idx, rd_idx, mem_idx;
   logic [DATA_W-1:0] mem_wdata, rd_word;

   assign busy        = (state_q == ST_CLEAR);
   assign wr_in_range = ({1'b0, bus.write_addr} < DEPTH_X);
   assign rd_in_range = ({1'b0, bus.read_addr} < DEPTH_X);
   assign wr_idx      = bus.write_addr[IDX_W-1:0];
   assign rd_idx      = bus.read_addr[IDX_W-1:0];

   // Memory is never touched in a reset cycle, so a reset mid-sweep stops clearing at once.
   assign user_we   = bus.we & ~busy & wr_in_range & ~reset;
   assign sweep_we  = busy & ~reset;
   assign mem_we    = user_we | sweep_we;
   assign mem_idx   = sweep_we ? cnt_q : wr_idx;
   assign mem_wdata = sweep_we ? CLEAR_VAL : bus.data_in;

   always_comb begin
      rd_word = CLEAR_VAL;
      if (rd_in_range) begin
`ifdef FRAMEBUF_BYPASS_EN
         if (mem_we && (mem_idx == rd_idx)) begin
            rd_word = mem_wdata;
         end else begin
            rd_word = mem[rd_idx];
         end
`else
         rd_word = mem[rd_idx];
`endif
      end else begin
         rd_word = CLEAR_VAL;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.clear) begin
               state_d = ST_CLEAR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == LAST_IDX) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               state_d = ST_CLEAR;
               cnt_d   = cnt_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      data_valid_d = bus.re;
      if (bus.re) begin
         data_out_d = rd_word;
      end else begin
         data_out_d = data_out_q;
      end
      wr_drop_d = bus.we & (busy | ~wr_in_range);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         wr_drop_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         wr_drop_q    <= wr_drop_d;
      end
   end

   // Storage has no reset; software fills it with a clear sweep.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_wdata;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.busy       = busy;
   assign bus.wr_drop    = wr_drop_q;
endmodule

// File: tb/tb_framebuf_2port.sv
// Self-checking bench for framebuf_2port: a cycle-stepped driver predicts each cycle's outputs
// from an array-based reference model and queues them; a negedge monitor pops and compares.
module tb_framebuf_2port;
   localparam int          DATA_W = 8;
   localparam int          ADDR_W = 12;
   localparam int          DEPTH  = 2048;
   localparam int          AMAX   = (1 << ADDR_W) - 1;
   localparam logic [7:0]  CLR    = 8'h00;

   typedef struct {
      bit         valid;
      bit         drop;
      bit         busy;
      logic [7:0] data;
      bit         dknown;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   framebuf_2port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

   framebuf_2port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_VAL(CLR)
   ) dut (
      .clk(clk), .reset(reset), .bus(bif)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [7:0] m_mem [DEPTH];
   bit         m_kn  [DEPTH];
   bit         sw_active = 1'b0;
   int         sw_start  = 0;
   int         cyc       = 0;
   logic [7:0] m_dout    = 8'h00;
   bit         m_dknown  = 1'b1;

   exp_t exp_q [$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, c, got, exp);
      end
   endtask

   function automatic bit m_busy_now();
      return sw_active && (cyc >= sw_start) && ((cyc - sw_start) < DEPTH);
   endfunction

   task automatic step(input bit rst, input bit we, input int wa, input logic [7:0] din,
                       input bit re, input int ra, input bit clr);
      exp_t e;
      bit   busy_now;
      int   sidx;
      reset          = rst;
      bif.we         = we;
      bif.write_addr = ADDR_W'(wa);
      bif.data_in    = din;
      bif.re         = re;
      bif.read_addr  = ADDR_W'(ra);
      bif.clear      = clr;
      busy_now = m_busy_now();
      sidx     = cyc - sw_start;
      e.valid  = 1'b0;
      e.drop   = 1'b0;
      if (rst) begin
         sw_active = 1'b0;
         m_dout    = 8'h00;
         m_dknown  = 1'b1;
      end else begin
         if (re) begin
            e.valid = 1'b1;
            if (ra >= DEPTH) begin
               m_dout   = CLR;
               m_dknown = 1'b1;
            end else begin
               m_dout   = m_mem[ra];
               m_dknown = m_kn[ra];
`ifdef FRAMEBUF_BYPASS_EN
               if (we && !busy_now && wa == ra) begin
                  m_dout   = din;
                  m_dknown = 1'b1;
               end else if (busy_now && sidx == ra) begin
                  m_dout   = CLR;
                  m_dknown = 1'b1;
               end
`endif
            end
         end
         e.drop = we && (busy_now || wa >= DEPTH);
         if (we && !busy_now && wa < DEPTH) begin
            m_mem[wa] = din;
            m_kn[wa]  = 1'b1;
         end
         if (busy_now) begin
            m_mem[sidx] = CLR;
            m_kn[sidx]  = 1'b1;
         end else if (clr) begin
            sw_active = 1'b1;
            sw_start  = cyc + 1;
         end
      end
      cyc++;
      e.busy = sw_active && ((cyc - sw_start) < DEPTH);
      if (!e.busy) sw_active = 1'b0;
      e.data   = m_dout;
      e.dknown = m_dknown;
      e.cyc    = cyc;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
   endtask

   task automatic rd(input int a);
      step(1'b0, 1'b0, 0, 8'h00, 1'b1, a, 1'b0);
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      step(1'b0, 1'b1, a, d, 1'b0, 0, 1'b0);
   endtask

   function automatic int rand_addr();
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) return int'($urandom_range(DEPTH, AMAX));
      else if (sel < 4) return int'($urandom_range(0, 15));
      else return int'($urandom_range(0, DEPTH - 1));
   endfunction

   // Monitor: compare each cycle's outputs against the queued prediction.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("busy", mon_e.cyc, 32'(bif.busy), 32'(mon_e.busy));
         chk("wr_drop", mon_e.cyc, 32'(bif.wr_drop), 32'(mon_e.drop));
         chk("data_valid", mon_e.cyc, 32'(bif.data_valid), 32'(mon_e.valid));
         if (mon_e.dknown) begin
            chk("data_out", mon_e.cyc, 32'(bif.data_out), 32'(mon_e.data));
         end
      end
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = 8'h00;
         m_kn[i]  = 1'b0;
      end
      reset = 1'b1; bif.we = 1'b0; bif.write_addr = '0; bif.data_in = '0;
      bif.re = 1'b0; bif.read_addr = '0; bif.clear = 1'b0;

      repeat (2) step(1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
      // basic write then read
      wr(100, 8'h5A); rd(100); idle();
      // out-of-range write dropped, aliasing address untouched, out-of-range read gives fill
      wr(0, 8'h33); wr(DEPTH, 8'h77); wr(AMAX, 8'h78); rd(0); rd(DEPTH); rd(AMAX); idle();
      // full clear with traffic, including ignored re-clear requests
      step(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
      repeat (DEPTH + 4) begin
         step(1'b0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), 1'($urandom_range(0, 1)),
              rand_addr(), m_busy_now() && ($urandom_range(0, 49) == 0));
      end
      rd(0); rd(1234); rd(DEPTH - 1);
      // read-before-write versus bypass on a same-address collision
      wr(7, 8'h11);
      step(1'b0, 1'b1, 7, 8'h22, 1'b1, 7, 1'b0);
      rd(7);
      // write and clear together: write lands, then the sweep overwrites it
      step(1'b0, 1'b1, 5, 8'h99, 1'b0, 0, 1'b1);
      rd(5);
      repeat (DEPTH + 2) idle();
      rd(5);
      // reset aborts the sweep at counter 1000; inputs in the reset cycle are ignored
      wr(1001, 8'hAB); wr(999, 8'hCD); wr(1002, 8'hEF);
      step(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
      repeat (1000) idle();
      step(1'b1, 1'b1, 1002, 8'h44, 1'b1, 999, 1'b1);
      rd(999); rd(1001); rd(1002); idle();
      // random traffic
      repeat (1500) begin
         step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom),
              1'($urandom_range(0, 1)), rand_addr(), $urandom_range(0, 399) == 0);
      end
      idle();
      @(negedge clk);
      #1;
      chk("drain", cyc, 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
